// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle ALU, HI/LO forwarding and a two-cycle
// multiply-accumulate sequencer for MADD/MADDU/MSUB/MSUBU.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alusel_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  input  logic        stall_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_MATH  = 3'b100;
  localparam logic [2:0] RES_MUL   = 3'b101;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
  localparam logic [7:0] OP_CLO   = 8'b1011_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;
  localparam logic [7:0] OP_MADD  = 8'b1010_0110;
  localparam logic [7:0] OP_MADDU = 8'b1010_1000;
  localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
  localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_prod_q;

  logic [31:0] w_hi_f, w_lo_f;
  logic [63:0] w_prod_s, w_prod_u, w_madd_prod;
  logic [32:0] w_add_ext, w_sub_ext;
  logic        w_add_ov, w_sub_ov;
  logic        w_is_madd, w_is_msub, w_is_madd_signed;
  logic [5:0]  w_clz, w_clo;
  logic [31:0] w_logic, w_shift, w_move, w_math;

  // Most recent HI/LO writer wins: MEM is younger than WB.
  assign w_hi_f = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
  assign w_lo_f = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

  assign w_prod_s = $signed(reg1_i) * $signed(reg2_i);
  assign w_prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

  assign w_is_madd        = (aluop_i == OP_MADD) || (aluop_i == OP_MADDU) ||
                            (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
  assign w_is_msub        = (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
  assign w_is_madd_signed = (aluop_i == OP_MADD) || (aluop_i == OP_MSUB);
  assign w_madd_prod = w_is_msub ? (~(w_is_madd_signed ? w_prod_s : w_prod_u) + 64'd1)
                                 : (w_is_madd_signed ? w_prod_s : w_prod_u);

  // 33-bit sign-extended arithmetic: overflow iff the top two bits disagree.
  assign w_add_ext = {reg1_i[31], reg1_i} + {reg2_i[31], reg2_i};
  assign w_sub_ext = {reg1_i[31], reg1_i} - {reg2_i[31], reg2_i};
  assign w_add_ov  = w_add_ext[32] ^ w_add_ext[31];
  assign w_sub_ov  = w_sub_ext[32] ^ w_sub_ext[31];

  always_comb begin
    w_clz = 6'd32;
    w_clo = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (reg1_i[i])  w_clz = 6'(31 - i);
      if (!reg1_i[i]) w_clo = 6'(31 - i);
    end
  end

  always_comb begin
    w_logic = 32'd0;
    w_shift = 32'd0;
    w_move  = 32'd0;
    w_math  = 32'd0;
    case (aluop_i)
      OP_AND:  w_logic = reg1_i & reg2_i;
      OP_OR:   w_logic = reg1_i | reg2_i;
      OP_XOR:  w_logic = reg1_i ^ reg2_i;
      OP_NOR:  w_logic = ~(reg1_i | reg2_i);
      default: w_logic = 32'd0;
    endcase
    case (aluop_i)
      OP_SLL:  w_shift = reg2_i << reg1_i[4:0];
      OP_SRL:  w_shift = reg2_i >> reg1_i[4:0];
      OP_SRA:  w_shift = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default: w_shift = 32'd0;
    endcase
    case (aluop_i)
      OP_MFHI:          w_move = w_hi_f;
      OP_MFLO:          w_move = w_lo_f;
      OP_MOVZ, OP_MOVN: w_move = reg1_i;
      default:          w_move = 32'd0;
    endcase
    case (aluop_i)
      OP_ADD, OP_ADDU: w_math = w_add_ext[31:0];
      OP_SUB, OP_SUBU: w_math = w_sub_ext[31:0];
      OP_SLT:          w_math = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU:         w_math = {31'd0, reg1_i < reg2_i};
      OP_CLZ:          w_math = {26'd0, w_clz};
      OP_CLO:          w_math = {26'd0, w_clo};
      default:         w_math = 32'd0;
    endcase
  end

  always_comb begin
    wdata_o      = 32'd0;
    waddr_o      = waddr_i;
    we_o         = we_i;
    whilo_o      = 1'b0;
    hi_o         = 32'd0;
    lo_o         = 32'd0;
    stallreq_o   = 1'b0;
    w_state_next = r_state;

    case (alusel_i)
      RES_LOGIC: wdata_o = w_logic;
      RES_SHIFT: wdata_o = w_shift;
      RES_MOVE:  wdata_o = w_move;
      RES_MATH:  wdata_o = w_math;
      RES_MUL:   wdata_o = w_prod_s[31:0];
      default:   wdata_o = 32'd0;
    endcase
    if (aluop_i == OP_NOP) wdata_o = 32'd0;

    if ((aluop_i == OP_ADD && w_add_ov) || (aluop_i == OP_SUB && w_sub_ov))
      we_o = 1'b0;

    case (aluop_i)
      OP_MULT:  begin whilo_o = 1'b1; {hi_o, lo_o} = w_prod_s; we_o = 1'b0; end
      OP_MULTU: begin whilo_o = 1'b1; {hi_o, lo_o} = w_prod_u; we_o = 1'b0; end
      OP_MTHI:  begin whilo_o = 1'b1; hi_o = reg1_i; lo_o = w_lo_f; we_o = 1'b0; end
      OP_MTLO:  begin whilo_o = 1'b1; hi_o = w_hi_f; lo_o = reg1_i; we_o = 1'b0; end
      default: ;
    endcase

    // First cycle captures the product and stalls; second cycle accumulates.
    if (r_state == S_IDLE) begin
      if (w_is_madd) begin
        we_o         = 1'b0;
        stallreq_o   = 1'b1;
        w_state_next = S_ACC;
      end
    end else begin
      w_state_next = S_IDLE;
      if (w_is_madd) begin
        we_o         = 1'b0;
        whilo_o      = 1'b1;
        {hi_o, lo_o} = {w_hi_f, w_lo_f} + r_prod_q;
      end
    end

    if (!rst) begin
      wdata_o    = 32'd0;
      waddr_o    = 5'd0;
      we_o       = 1'b0;
      whilo_o    = 1'b0;
      hi_o       = 32'd0;
      lo_o       = 32'd0;
      stallreq_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_prod_q <= 64'd0;
    end else if (!stall_i) begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_is_madd) r_prod_q <= w_madd_prod;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, overflow suppression,
// HI/LO forwarding, stall handling and the MADD/MSUB sequencer.
module tb_ex_stage;
  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_MATH  = 3'b100;
  localparam logic [2:0] RES_MUL   = 3'b101;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
  localparam logic [7:0] OP_CLO   = 8'b1011_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;
  localparam logic [7:0] OP_MADD  = 8'b1010_0110;
  localparam logic [7:0] OP_MSUB  = 8'b1010_1010;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic [31:0] hi_i, lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i, mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i, wb_lo_i;
  logic        stall_i;
  logic [31:0] wdata_o;
  logic [4:0]  waddr_o;
  logic        we_o, whilo_o, stallreq_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .alusel_i(alusel_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i), .we_i(we_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
    .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
    .stall_i(stall_i), .wdata_o(wdata_o), .waddr_o(waddr_o), .we_o(we_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] sel, input logic [7:0] aop,
                    input logic [31:0] a, input logic [31:0] b);
    alusel_i = sel;
    aluop_i  = aop;
    reg1_i   = a;
    reg2_i   = b;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    waddr_i = 5'd3; we_i = 1'b1;
    hi_i = 32'd0; lo_i = 32'd0;
    mem_whilo_i = 1'b0; mem_hi_i = 32'd0; mem_lo_i = 32'd0;
    wb_whilo_i = 1'b0; wb_hi_i = 32'd0; wb_lo_i = 32'd0;
    stall_i = 1'b0;
    op(RES_MATH, OP_ADDU, 32'd5, 32'd6);
    chk("rst_wdata", {32'd0, wdata_o}, 64'd0);
    chk("rst_we_waddr", {58'd0, we_o, waddr_o}, 64'd0);
    chk("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
    #3 rst = 1'b1;
    #1;

    op(RES_MATH, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_we", {63'd0, we_o}, 64'd0);
    op(RES_MATH, OP_ADDU, 32'h7FFF_FFFF, 32'd1);
    chk("addu_wdata", {32'd0, wdata_o}, 64'h8000_0000);
    chk("addu_we", {63'd0, we_o}, 64'd1);
    chk("addu_waddr", {59'd0, waddr_o}, 64'd3);
    op(RES_MATH, OP_SUB, 32'h8000_0000, 32'd1);
    chk("sub_ovf_we", {63'd0, we_o}, 64'd0);
    op(RES_MATH, OP_SUB, 32'hFFFF_FFFF, 32'h8000_0000);
    chk("sub_noovf", {31'd0, we_o, wdata_o}, {31'd0, 1'b1, 32'h7FFF_FFFF});

    op(RES_SHIFT, OP_SRA, 32'd4, 32'h8000_0010);
    chk("sra", {32'd0, wdata_o}, 64'hF800_0001);
    op(RES_MATH, OP_CLZ, 32'h0000_8000, 32'd0);
    chk("clz_16", {32'd0, wdata_o}, 64'd16);
    op(RES_MATH, OP_CLZ, 32'h0000_0000, 32'd0);
    chk("clz_zero", {32'd0, wdata_o}, 64'd32);
    op(RES_MATH, OP_CLO, 32'hFFFF_FFFF, 32'd0);
    chk("clo_ones", {32'd0, wdata_o}, 64'd32);
    op(RES_LOGIC, OP_OR, 32'h0000_F0F0, 32'h0000_0F00);
    chk("or", {32'd0, wdata_o}, 64'h0000_FFF0);
    op(RES_LOGIC, OP_NOR, 32'd0, 32'd0);
    chk("nor", {32'd0, wdata_o}, 64'hFFFF_FFFF);
    op(RES_MATH, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    chk("slt", {32'd0, wdata_o}, 64'd1);
    op(RES_MATH, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", {32'd0, wdata_o}, 64'd0);
    op(RES_MUL, OP_MUL, 32'hFFFF_FFFD, 32'd5);
    chk("mul", {32'd0, wdata_o}, 64'hFFFF_FFF1);

    op(RES_NOP, OP_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mult_flags", {62'd0, whilo_o, we_o}, 64'b10);
    op(RES_NOP, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    lo_i = 32'h55;
    op(RES_NOP, OP_MTHI, 32'h0000_AAAA, 32'd0);
    chk("mthi", {hi_o, lo_o}, 64'h0000_AAAA_0000_0055);
    chk("mthi_flags", {62'd0, whilo_o, we_o}, 64'b10);
    lo_i = 32'd0;

    hi_i = 32'd1; wb_hi_i = 32'd2; mem_hi_i = 32'd3;
    wb_whilo_i = 1'b1; mem_whilo_i = 1'b1;
    op(RES_MOVE, OP_MFHI, 32'd0, 32'd0);
    chk("fwd_mem", {32'd0, wdata_o}, 64'd3);
    mem_whilo_i = 1'b0;
    #1;
    chk("fwd_wb", {32'd0, wdata_o}, 64'd2);
    wb_whilo_i = 1'b0;
    #1;
    chk("fwd_arch", {32'd0, wdata_o}, 64'd1);
    hi_i = 32'd0;

    op(RES_NOP, OP_NOP, 32'h1234, 32'h5678);
    chk("nop", {31'd0, whilo_o, wdata_o}, 64'd0);

    // MADD 3x4 with HI/LO = 0:0x10, one downstream-stall cycle inserted.
    lo_i = 32'h10;
    @(negedge clk);
    op(RES_MUL, OP_MADD, 32'd3, 32'd4);
    chk("madd_c1", {61'd0, stallreq_o, whilo_o, we_o}, 64'b100);
    stall_i = 1'b1;
    @(posedge clk); #1;
    chk("madd_stall_hold", {62'd0, stallreq_o, whilo_o}, 64'b10);
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk("madd_c2_flags", {62'd0, stallreq_o, whilo_o}, 64'b01);
    chk("madd_c2_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_001C);
    @(posedge clk); #1;
    chk("madd_back_idle", {63'd0, stallreq_o}, 64'd1);
    op(RES_NOP, OP_NOP, 32'd0, 32'd0);

    // MSUB 1x1, reset while the product is held, then a clean rerun.
    lo_i = 32'd0;
    @(negedge clk);
    op(RES_MUL, OP_MSUB, 32'd1, 32'd1);
    chk("msub_c1", {62'd0, stallreq_o, whilo_o}, 64'b10);
    @(posedge clk); #1;
    chk("msub_acc_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b0;
    #1;
    chk("midrst_outs", {hi_o, lo_o} | {31'd0, stallreq_o, wdata_o}, 64'd0);
    chk("midrst_flags", {61'd0, whilo_o, we_o, stallreq_o}, 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("restart_c1", {62'd0, stallreq_o, whilo_o}, 64'b10);
    @(posedge clk); #1;
    chk("restart_c2", {31'd0, whilo_o, lo_o}, {31'd0, 1'b1, 32'hFFFF_FFFF});
    op(RES_NOP, OP_NOP, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
